mem_access_stage: RTL

- Memory stage that sits directly downstream of the register-read/load-store unit.
- Takes a decoded load/store carrying the base-register value and immediate offset, and computes the effective address.
- Runs one request/acknowledge transaction on the data-memory port, then aligns and extends load data.
- Returns load results as a one-cycle register-file write-back pulse. Misalignment and memory timeout are reported as one-cycle exception pulses.

---
 rtl/mem_access_stage.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// Memory stage: effective-address generation, one req/ack data-memory transaction,
// load lane alignment/extension, and one-cycle write-back / exception pulses.
module mem_access_stage #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              op_is_store,
  input  logic [1:0]        op_size,
  input  logic              op_unsigned,
  input  logic [63:0]       op_base,
  input  logic [11:0]       op_offset,
  input  logic [63:0]       op_store_data,
  input  logic [4:0]        op_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wstrb,
  input  logic              mem_ack,
  input  logic [63:0]       mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_reg,
  output logic [63:0]       wb_data,
  output logic              exc_valid,
  output logic [1:0]        exc_cause
);

  // state | meaning
  // IDLE  | ready for a new operation
  // WAIT  | mem_req held, waiting for mem_ack or timeout
  // RESP  | write-back cycle after the ack
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             q_store;
  logic             q_unsigned;
  logic [1:0]       q_size;
  logic [4:0]       q_rd;
  logic [2:0]       q_off;

  logic [63:0] ea_full;
  logic [2:0]  ea_off;
  logic        misaligned;
  logic [7:0]  size_mask;
  logic [63:0] lane;
  logic [63:0] load_val;
  logic        unused_ea;

  // Upper sum bits beyond ADDR_W are simply discarded, giving the modulo wrap.
  assign ea_full   = op_base + 64'($signed(op_offset));
  assign ea_off    = ea_full[2:0];
  assign unused_ea = ^ea_full;
  assign op_ready  = (state == IDLE);

  always_comb begin
    misaligned = 1'b0;
    size_mask  = 8'h01;
    case (op_size)
      2'b01: begin misaligned = ea_off[0];     size_mask = 8'h03; end
      2'b10: begin misaligned = |ea_off[1:0];  size_mask = 8'h0F; end
      2'b11: begin misaligned = |ea_off;       size_mask = 8'hFF; end
      default: begin misaligned = 1'b0;        size_mask = 8'h01; end
    endcase
  end

  assign lane = mem_rdata >> {q_off, 3'b000};

  always_comb begin
    load_val = lane;
    case (q_size)
      2'b00: load_val = q_unsigned ? {56'd0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
      2'b01: load_val = q_unsigned ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
      2'b10: load_val = q_unsigned ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
      default: load_val = lane;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      q_store    <= 1'b0;
      q_unsigned <= 1'b0;
      q_size     <= 2'b00;
      q_rd       <= 5'd0;
      q_off      <= 3'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      wb_valid   <= 1'b0;
      wb_reg     <= 5'd0;
      wb_data    <= '0;
      exc_valid  <= 1'b0;
      exc_cause  <= 2'b00;
    end else begin
      wb_valid  <= 1'b0;
      exc_valid <= 1'b0;
      exc_cause <= 2'b00;
      case (state)
        IDLE: begin
          if (op_valid) begin
            if (misaligned) begin
              exc_valid <= 1'b1;
              exc_cause <= 2'b01;
            end else begin
              state      <= WAIT;
              cnt        <= CNT_LOAD;
              q_store    <= op_is_store;
              q_unsigned <= op_unsigned;
              q_size     <= op_size;
              q_rd       <= op_rd;
              q_off      <= ea_off;
              mem_req    <= 1'b1;
              mem_we     <= op_is_store;
              mem_addr   <= {ea_full[ADDR_W-1:3], 3'b000};
              mem_wdata  <= op_is_store ? (op_store_data << {ea_off, 3'b000}) : 64'd0;
              mem_wstrb  <= op_is_store ? (size_mask << ea_off) : 8'd0;
            end
          end
        end
        WAIT: begin
          // An ack on the final allowed cycle takes priority over the timeout.
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= RESP;
            if (!q_store && q_rd != 5'd0) begin
              wb_valid <= 1'b1;
              wb_reg   <= q_rd;
              wb_data  <= load_val;
            end
          end else if (cnt == '0) begin
            mem_req   <= 1'b0;
            exc_valid <= 1'b1;
            exc_cause <= 2'b10;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
